// File: rtl/ring_step_ctrl.sv
// ring_step_ctrl: advances a ring or Johnson pattern once per selected rising edge
// of the slow divider outputs or a manual step button. The slow signals are
// synchronized and edge-detected in the clk domain; they are never used as clocks.
//
// Ports:
//   clk      fast system clock
//   clr      asynchronous active-high reset
//   slow_in  divider outputs: [0] slowest, [1] medium, [2] fastest
//   sel      step source: 00/01/10 pick slow_in[sel], 11 picks step
//   step     manual step button (debounced, asynchronous)
//   dir      0 shifts toward the MSB, 1 shifts toward the LSB
//   mode     0 ring (one-hot), 1 Johnson (twisted ring)
//   run      1 allows advancing, 0 freezes q
//   q        registered counter pattern
//   tick     one-cycle pulse aligned with each newly advanced q
//   err      sticky flag, set when an illegal pattern is seen at an advance
module ring_step_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [2:0]       slow_in,
    input  logic [1:0]       sel,
    input  logic             step,
    input  logic             dir,
    input  logic             mode,
    input  logic             run,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             err
);

    localparam int unsigned NSRC = 4;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
    logic [NSRC-1:0]                  hist_q, hist_d;
    logic [NSRC-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                 q_q, q_d;
    logic                             mode_q, mode_d;
    logic                             tick_q, tick_d;
    logic                             err_q, err_d;

    logic                             mode_chg_c;
    logic                             adv_c;
    logic                             legal_c;
    logic [WIDTH-2:0]                 jdiff_c;
    logic [WIDTH-1:0]                 base_c;
    logic [WIDTH-1:0]                 step_c;

    // Synchronizer chains, history and registered per-source rising edges.
    // Edges are detected before the source mux so changing sel cannot fake one.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {step, slow_in};
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Advance qualification, legality check and candidate next patterns.
    always_comb begin
        mode_chg_c = mode ^ mode_q;
        adv_c      = rise_q[sel] & run & ~mode_chg_c;
        jdiff_c    = q_q[WIDTH-2:0] ^ q_q[WIDTH-1:1];
        legal_c    = mode_q ? $onehot0(jdiff_c) : $onehot(q_q);
        base_c     = mode ? '0 : WIDTH'(1);
        step_c     = q_q;
        if (!mode_q) begin
            step_c = dir ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        end else begin
            step_c = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
    end

    // Next state: mode reload beats advance; an illegal pattern reloads the base.
    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        err_d  = err_q;
        mode_d = mode;
        if (mode_chg_c) begin
            q_d = base_c;
        end else if (adv_c) begin
            tick_d = 1'b1;
            if (legal_c) begin
                q_d = step_c;
            end else begin
                q_d   = base_c;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            hist_q <= '0;
            rise_q <= '0;
            q_q    <= WIDTH'(1);
            mode_q <= 1'b0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            q_q    <= q_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ring_step_ctrl.sv
// Testbench for ring_step_ctrl (WIDTH=8, SYNC_STAGES=2). Directed edges push the
// hand-computed q/err and the tick cycle into a scoreboard; a monitor pops and
// compares on every tick, and flags unexpected or overdue ticks.
module tb_ring_step_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] slow_in;
    logic [1:0] sel;
    logic       step;
    logic       dir;
    logic       mode;
    logic       run;
    logic [7:0] q;
    logic       tick;
    logic       err;

    typedef struct {
        logic [7:0] q;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    ring_step_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .clr     (clr),
        .slow_in (slow_in),
        .sel     (sel),
        .step    (step),
        .dir     (dir),
        .mode    (mode),
        .run     (run),
        .q       (q),
        .tick    (tick),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick must match the oldest expected advance.
    always @(negedge clk) begin
        exp_t e;
        if (!clr) begin
            if (tick) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_tick: got q=%0h with no advance expected (cycle %0d)", q, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("tick_q", 32'(q), 32'(e.q));
                    chk("tick_err", 32'(err), 32'(e.err));
                    chk("tick_latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missing_tick: got none expected q=%0h by cycle %0d", e.q, e.cyc);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int idx, input logic v);
        if (idx == 3) step = v;
        else          slow_in[idx] = v;
    endtask

    // One rising edge on a source; called at a negedge. Sampled at the next edge,
    // so the advance lands 4 posedges after the drive cycle.
    task automatic src_edge(input int idx, input logic [7:0] eq, input logic ee, input bit adv);
        exp_t e;
        set_src(idx, 1'b1);
        if (adv) begin
            e.q   = eq;
            e.err = ee;
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
        wait_neg(6);
        set_src(idx, 1'b0);
        wait_neg(4);
    endtask

    logic [7:0] john_tab [16];

    initial begin
        john_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        clr     = 1'b1;
        slow_in = 3'b000;
        sel     = 2'b10;
        step    = 1'b0;
        dir     = 1'b0;
        mode    = 1'b0;
        run     = 1'b1;
        wait_neg(2);
        chk("reset_q", 32'(q), 32'h01);
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        clr = 1'b0;
        wait_neg(2);

        // Speed select: slow_in[2] advances, slow_in[0] is ignored.
        src_edge(2, 8'h02, 1'b0, 1'b1);
        src_edge(2, 8'h04, 1'b0, 1'b1);
        src_edge(2, 8'h08, 1'b0, 1'b1);
        src_edge(0, 8'h00, 1'b0, 1'b0);
        src_edge(0, 8'h00, 1'b0, 1'b0);
        chk("unselected_hold", 32'(q), 32'h08);

        // Ring wrap both directions.
        src_edge(2, 8'h10, 1'b0, 1'b1);
        src_edge(2, 8'h20, 1'b0, 1'b1);
        src_edge(2, 8'h40, 1'b0, 1'b1);
        src_edge(2, 8'h80, 1'b0, 1'b1);
        src_edge(2, 8'h01, 1'b0, 1'b1);
        dir = 1'b1;
        src_edge(2, 8'h80, 1'b0, 1'b1);
        src_edge(2, 8'h40, 1'b0, 1'b1);

        // Johnson: reload to zero without tick, then a full 16-step period.
        mode = 1'b1;
        wait_neg(1);
        chk("johnson_reload_q", 32'(q), 32'h00);
        chk("johnson_reload_tick", 32'(tick), 32'h0);
        dir = 1'b0;
        sel = 2'b11;
        for (int i = 0; i < 16; i++) begin
            src_edge(3, john_tab[i], 1'b0, 1'b1);
        end

        // Pause drops edges.
        run = 1'b0;
        src_edge(3, 8'h00, 1'b0, 1'b0);
        src_edge(3, 8'h00, 1'b0, 1'b0);
        run = 1'b1;
        wait_neg(4);
        chk("pause_hold", 32'(q), 32'h00);

        // Switching sel onto a source that is already high gives no advance.
        sel = 2'b00;
        slow_in[1] = 1'b1;
        wait_neg(8);
        sel = 2'b01;
        wait_neg(8);
        chk("sel_glitch_hold", 32'(q), 32'h00);
        slow_in[1] = 1'b0;
        wait_neg(4);

        // Illegal ring pattern recovers to the base and sets sticky err.
        mode = 1'b0;
        wait_neg(2);
        chk("ring_reload_q", 32'(q), 32'h01);
        force dut.q_q = 8'h05;
        wait_neg(1);
        release dut.q_q;
        sel = 2'b10;
        src_edge(2, 8'h01, 1'b1, 1'b1);
        src_edge(2, 8'h02, 1'b1, 1'b1);
        chk("err_sticky", 32'(err), 32'h1);
        clr = 1'b1;
        wait_neg(1);
        clr = 1'b0;
        wait_neg(1);
        chk("clr_q", 32'(q), 32'h01);
        chk("clr_err", 32'(err), 32'h0);

        // Mode change in the same cycle the edge would advance: reload only.
        slow_in[2] = 1'b1;
        wait_neg(3);
        mode = 1'b1;
        wait_neg(6);
        slow_in[2] = 1'b0;
        wait_neg(4);
        chk("collision_q", 32'(q), 32'h00);

        // Asynchronous clear with an edge in flight.
        sel = 2'b11;
        src_edge(3, 8'h01, 1'b0, 1'b1);
        src_edge(3, 8'h03, 1'b0, 1'b1);
        step = 1'b1;
        wait_neg(2);
        #1;
        clr  = 1'b1;
        step = 1'b0;
        #1;
        chk("async_clr_q", 32'(q), 32'h01);
        chk("async_clr_tick", 32'(tick), 32'h0);
        chk("async_clr_err", 32'(err), 32'h0);
        wait_neg(1);
        clr = 1'b0;
        wait_neg(8);
        chk("post_clr_mode_reload", 32'(q), 32'h00);

        wait_neg(10);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
